// File: rtl/ls_control_unit_if.sv
// ---------------------------------------------------------------------------
// ls_control_unit_if
// Bundle between the load/store control sequencer and the Mini-SRC datapath.
//   ir          : IR contents from the datapath (opcode in ir[31:27])
//   mem_ready   : memory handshake (only honoured with LS_CTRL_MEM_WAIT_EN)
//   PCout..ADD  : datapath control strobes, one-to-one with Datapath inputs
//   run         : 1 while executing, 0 in HALT
//   instr_done  : one-cycle pulse in the final state of each instruction
// Modports:
//   master : the control unit (drives strobes, reads ir/mem_ready)
//   slave  : the datapath side (reads strobes, drives ir/mem_ready)
// ---------------------------------------------------------------------------
interface ls_control_unit_if;
   logic [31:0] ir;
   logic        mem_ready;
   logic        PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
   logic        Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowin, Zlowout;
   logic        ADD;
   logic        run;
   logic        instr_done;

   modport master (
      input  ir, mem_ready,
      output PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
      output Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowin, Zlowout,
      output ADD, run, instr_done
   );

   modport slave (
      output ir, mem_ready,
      input  PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
      input  Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowin, Zlowout,
      input  ADD, run, instr_done
   );
endinterface

// File: rtl/ls_control_unit.sv
// ---------------------------------------------------------------------------
// ls_control_unit
// Control sequencer for the Mini-SRC load/store class (ld, ldi, st, nop,
// halt). Steps the T0..T7 micro-states and decodes the datapath strobes from
// the state register and the opcode in ir[31:27].
// Ports:
//   clock : system clock, rising edge active
//   clear : synchronous active-low reset
//   bus   : ls_control_unit_if.master (ir, mem_ready, strobes, run,
//           instr_done)
// Optional feature macro: LS_CTRL_MEM_WAIT_EN
//   When defined, T1, ld-T6 and st-T7 stall until mem_ready=1, and the st-T7
//   instr_done pulse is qualified by mem_ready. When undefined, mem_ready is
//   ignored and memory is single-cycle.
// ---------------------------------------------------------------------------
module ls_control_unit #(
   parameter logic [4:0] OPC_LD   = 5'b00000,
   parameter logic [4:0] OPC_LDI  = 5'b00001,
   parameter logic [4:0] OPC_ST   = 5'b00010,
   parameter logic [4:0] OPC_HALT = 5'b11011
) (
   input logic              clock,
   input logic              clear,
   ls_control_unit_if.master bus
);

   typedef enum logic [3:0] {
      ST_DEFAULT = 4'b0000,
      ST_T0      = 4'b0111,
      ST_T1      = 4'b1000,
      ST_T2      = 4'b1001,
      ST_T3      = 4'b1010,
      ST_T4      = 4'b1011,
      ST_T5      = 4'b1100,
      ST_T6      = 4'b1101,
      ST_T7      = 4'b1110,
      ST_HALT    = 4'b1111
   } state_t;

   state_t     state;
   logic [4:0] opc;
   logic       is_ld, is_ldi, is_st, is_ls;
   logic       mem_go;
   logic       unused_bits;

   assign opc    = bus.ir[31:27];
   assign is_ld  = (opc == OPC_LD);
   assign is_ldi = (opc == OPC_LDI);
   assign is_st  = (opc == OPC_ST);
   assign is_ls  = is_ld | is_ldi | is_st;

`ifdef LS_CTRL_MEM_WAIT_EN
   // Memory states advance only when the memory acknowledges.
   assign mem_go      = bus.mem_ready;
   assign unused_bits = ^bus.ir[26:0];
`else
   // Single-cycle memory: the handshake is ignored.
   assign mem_go      = 1'b1;
   assign unused_bits = ^{bus.ir[26:0], bus.mem_ready};
`endif

   // Micro-state sequencer; clear=0 wins over every state including HALT.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state <= ST_DEFAULT;
      end else begin
         case (state)
            ST_DEFAULT: state <= ST_T0;
            ST_T0:      state <= ST_T1;
            ST_T1: begin
               if (mem_go) state <= ST_T2;
               else        state <= ST_T1;
            end
            ST_T2:      state <= ST_T3;
            ST_T3: begin
               if (is_ls)                 state <= ST_T4;
               else if (opc == OPC_HALT)  state <= ST_HALT;
               else                       state <= ST_T0;
            end
            ST_T4:      state <= ST_T5;
            ST_T5: begin
               // Only ld/st reach T5 besides ldi; anything else is abandoned.
               if (is_ldi)       state <= ST_T0;
               else if (is_ls)   state <= ST_T6;
               else              state <= ST_DEFAULT;
            end
            ST_T6: begin
               if (is_ld && !mem_go) state <= ST_T6;
               else                  state <= ST_T7;
            end
            ST_T7: begin
               if (is_st && !mem_go) state <= ST_T7;
               else                  state <= ST_T0;
            end
            ST_HALT:    state <= ST_HALT;
            default:    state <= ST_DEFAULT;
         endcase
      end
   end

   // Strobe decode from the state register and opcode (Moore plus opcode).
   always_comb begin
      bus.PCout      = 1'b0;
      bus.MARin      = 1'b0;
      bus.IncPC      = 1'b0;
      bus.PCin       = 1'b0;
      bus.Read       = 1'b0;
      bus.Write      = 1'b0;
      bus.MDRin      = 1'b0;
      bus.MDRout     = 1'b0;
      bus.IRin       = 1'b0;
      bus.Gra        = 1'b0;
      bus.Grb        = 1'b0;
      bus.Rin        = 1'b0;
      bus.Rout       = 1'b0;
      bus.BAout      = 1'b0;
      bus.Yin        = 1'b0;
      bus.Cout       = 1'b0;
      bus.Zlowin     = 1'b0;
      bus.Zlowout    = 1'b0;
      bus.ADD        = 1'b0;
      bus.run        = 1'b1;
      bus.instr_done = 1'b0;
      case (state)
         ST_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.PCin  = 1'b1;
         end
         ST_T1: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
         end
         ST_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         ST_T3: begin
            if (is_ls) begin
               bus.Grb   = 1'b1;
               bus.BAout = 1'b1;
               bus.Yin   = 1'b1;
            end else if (opc == OPC_HALT) begin
               bus.instr_done = 1'b0;
            end else begin
               bus.instr_done = 1'b1;
            end
         end
         ST_T4: begin
            bus.Cout   = 1'b1;
            bus.Zlowin = 1'b1;
            bus.ADD    = 1'b1;
         end
         ST_T5: begin
            if (is_ldi) begin
               bus.Zlowout    = 1'b1;
               bus.Gra        = 1'b1;
               bus.Rin        = 1'b1;
               bus.instr_done = 1'b1;
            end else if (is_ls) begin
               bus.Zlowout = 1'b1;
               bus.MARin   = 1'b1;
            end else begin
               bus.Zlowout = 1'b0;
            end
         end
         ST_T6: begin
            if (is_ld) begin
               bus.Read  = 1'b1;
               bus.MDRin = 1'b1;
            end else if (is_st) begin
               bus.Gra   = 1'b1;
               bus.Rout  = 1'b1;
               bus.MDRin = 1'b1;
            end else begin
               bus.MDRin = 1'b0;
            end
         end
         ST_T7: begin
            if (is_ld) begin
               bus.MDRout     = 1'b1;
               bus.Gra        = 1'b1;
               bus.Rin        = 1'b1;
               bus.instr_done = 1'b1;
            end else if (is_st) begin
               // The store completes only in the cycle memory accepts it.
               bus.Write      = 1'b1;
               bus.instr_done = mem_go;
            end else begin
               bus.instr_done = 1'b0;
            end
         end
         ST_HALT: begin
            bus.run = 1'b0;
         end
         default: begin
            bus.run = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ls_control_unit.sv
// ---------------------------------------------------------------------------
// tb_ls_control_unit
// Self-checking bench for ls_control_unit. A reference model expands each
// instruction into its list of expected strobe sets and steps through it one
// clock at a time, honouring LS_CTRL_MEM_WAIT_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_ls_control_unit;

   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_LDI  = 5'b00001;
   localparam logic [4:0] OPC_ST   = 5'b00010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

`ifdef LS_CTRL_MEM_WAIT_EN
   localparam bit WAIT_MODE = 1'b1;
`else
   localparam bit WAIT_MODE = 1'b0;
`endif

   // Bit positions of the observed output vector.
   localparam logic [20:0] M_PCOUT   = 21'h000001;
   localparam logic [20:0] M_MARIN   = 21'h000002;
   localparam logic [20:0] M_INCPC   = 21'h000004;
   localparam logic [20:0] M_PCIN    = 21'h000008;
   localparam logic [20:0] M_READ    = 21'h000010;
   localparam logic [20:0] M_WRITE   = 21'h000020;
   localparam logic [20:0] M_MDRIN   = 21'h000040;
   localparam logic [20:0] M_MDROUT  = 21'h000080;
   localparam logic [20:0] M_IRIN    = 21'h000100;
   localparam logic [20:0] M_GRA     = 21'h000200;
   localparam logic [20:0] M_GRB     = 21'h000400;
   localparam logic [20:0] M_RIN     = 21'h000800;
   localparam logic [20:0] M_ROUT    = 21'h001000;
   localparam logic [20:0] M_BAOUT   = 21'h002000;
   localparam logic [20:0] M_YIN     = 21'h004000;
   localparam logic [20:0] M_COUT    = 21'h008000;
   localparam logic [20:0] M_ZLOWIN  = 21'h010000;
   localparam logic [20:0] M_ZLOWOUT = 21'h020000;
   localparam logic [20:0] M_ADD     = 21'h040000;
   localparam logic [20:0] M_RUN     = 21'h080000;
   localparam logic [20:0] M_DONE    = 21'h100000;

   typedef struct {
      logic [20:0] vec;
      bit          mem;
   } step_t;

   logic clock;
   logic clear;
   int   checks;
   int   failures;
   step_t steps[$];
   logic [20:0] obs;

   ls_control_unit_if bus ();

   ls_control_unit #(
      .OPC_LD   (OPC_LD),
      .OPC_LDI  (OPC_LDI),
      .OPC_ST   (OPC_ST),
      .OPC_HALT (OPC_HALT)
   ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   assign obs = {bus.instr_done, bus.run, bus.ADD, bus.Zlowout, bus.Zlowin,
                 bus.Cout, bus.Yin, bus.BAout, bus.Rout, bus.Rin, bus.Grb,
                 bus.Gra, bus.IRin, bus.MDRout, bus.MDRin, bus.Write, bus.Read,
                 bus.PCin, bus.IncPC, bus.MARin, bus.PCout};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expand an opcode into the strobe sets it must produce, one per cycle.
   task automatic build_steps(input logic [4:0] opc);
      steps.delete();
      steps.push_back('{M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_PCIN, 1'b0});
      steps.push_back('{M_RUN | M_READ | M_MDRIN, 1'b1});
      steps.push_back('{M_RUN | M_MDROUT | M_IRIN, 1'b0});
      if (opc == OPC_LD || opc == OPC_LDI || opc == OPC_ST) begin
         steps.push_back('{M_RUN | M_GRB | M_BAOUT | M_YIN, 1'b0});
         steps.push_back('{M_RUN | M_COUT | M_ZLOWIN | M_ADD, 1'b0});
         if (opc == OPC_LDI) begin
            steps.push_back('{M_RUN | M_ZLOWOUT | M_GRA | M_RIN | M_DONE, 1'b0});
         end else begin
            steps.push_back('{M_RUN | M_ZLOWOUT | M_MARIN, 1'b0});
            if (opc == OPC_LD) begin
               steps.push_back('{M_RUN | M_READ | M_MDRIN, 1'b1});
               steps.push_back('{M_RUN | M_MDROUT | M_GRA | M_RIN | M_DONE, 1'b0});
            end else begin
               steps.push_back('{M_RUN | M_GRA | M_ROUT | M_MDRIN, 1'b0});
               steps.push_back('{M_RUN | M_WRITE | M_DONE, 1'b1});
            end
         end
      end else if (opc == OPC_HALT) begin
         steps.push_back('{M_RUN, 1'b0});
      end else begin
         steps.push_back('{M_RUN | M_DONE, 1'b0});
      end
   endtask

   // Run one instruction from its T0 and compare every cycle to the model.
   // Entered and left one time unit after the rising edge that starts T0.
   // abort_step >= 0 pulls clear low during that step and stops there.
   task automatic test_instr_stream(input logic [31:0] instr, input bit rand_ready,
                                    input int abort_step, input string name);
      logic [20:0] expv;
      bit          ready;
      bit          stall;
      logic [31:0] junk;
      build_steps(instr[31:27]);
      for (int i = 0; i < steps.size(); i++) begin
         stall = 1'b0;
         do begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_ready = ready;
            if (i >= 3) begin
               bus.ir = instr;
            end else begin
               junk   = $urandom();
               bus.ir = junk;
            end
            @(negedge clock);
            expv = steps[i].vec;
            if (WAIT_MODE && steps[i].mem && !ready) expv = expv & ~M_DONE;
            checks++;
            if (obs !== expv) begin
               failures++;
               $display("FAIL %s step %0d: got %h expected %h", name, i, obs, expv);
            end
            stall = WAIT_MODE && steps[i].mem && !ready;
            if (i == abort_step) clear = 1'b0;
            @(posedge clock);
            #1;
         end while (stall && i != abort_step);
         if (i == abort_step) break;
      end
   endtask

   task automatic test_reset();
      clear         = 1'b0;
      bus.ir        = 32'h0000_0000;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (obs !== M_RUN) begin
         failures++;
         $display("FAIL reset_default: got %h expected %h", obs, M_RUN);
      end
      clear = 1'b1;
      @(negedge clock);
      checks++;
      if (obs !== M_RUN) begin
         failures++;
         $display("FAIL reset_release: got %h expected %h", obs, M_RUN);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_directed();
      test_instr_stream(32'h0080_0008, 1'b0, -1, "ld");
      test_instr_stream(32'h0880_0005, 1'b0, -1, "ldi");
      test_instr_stream(32'h1080_0010, 1'b0, -1, "st");
      test_instr_stream(32'hF800_0000, 1'b0, -1, "nop");
   endtask

   task automatic test_reset_mid_op();
      test_instr_stream(32'h0080_0008, 1'b0, 5, "ld_abort");
      clear = 1'b1;
      @(negedge clock);
      checks++;
      if (obs !== M_RUN) begin
         failures++;
         $display("FAIL mid_op_default: got %h expected %h", obs, M_RUN);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_halt();
      test_instr_stream({OPC_HALT, 27'h0000123}, 1'b0, -1, "halt_fetch");
      for (int c = 0; c < 20; c++) begin
         bus.mem_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         checks++;
         if (obs !== 21'h000000) begin
            failures++;
            $display("FAIL halt_hold cycle %0d: got %h expected %h", c, obs, 21'h000000);
         end
         @(posedge clock);
         #1;
      end
      clear = 1'b0;
      @(posedge clock);
      #1;
      clear = 1'b1;
      checks++;
      if (obs !== M_RUN) begin
         failures++;
         $display("FAIL halt_clear: got %h expected %h", obs, M_RUN);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [4:0]  opc;
      for (int n = 0; n < 30; n++) begin
         r = $urandom();
         case ($urandom_range(0, 3))
            0: opc = OPC_LD;
            1: opc = OPC_LDI;
            2: opc = OPC_ST;
            default: begin
               opc = 5'($urandom_range(3, 31));
               if (opc == OPC_HALT) opc = 5'b11111;
            end
         endcase
         test_instr_stream({opc, r[26:0]}, 1'b1, -1, "random");
      end
   endtask

   // Leaves the DUT mid-T0; restarts it through clear to realign.
   task automatic realign();
      clear = 1'b0;
      @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_mem_wait();
      int cyc;
      int reads;
      int writes;
      int dones;
      int done_at;
      bit seen_t0;
      // ld with mem_ready low for three cycles in T1
      cyc = 0; reads = 0; seen_t0 = 1'b0;
      while (cyc < 40 && !seen_t0) begin
         bus.ir        = 32'h0080_0008;
         bus.mem_ready = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
         @(negedge clock);
         if (cyc > 0 && obs[0]) begin
            seen_t0 = 1'b1;
         end else begin
            if (obs[4]) reads++;
            cyc++;
            @(posedge clock);
            #1;
         end
      end
      checks++;
      if (!seen_t0 || cyc != (WAIT_MODE ? 11 : 8)) begin
         failures++;
         $display("FAIL ld_wait_cycles: got %0d expected %0d", cyc, WAIT_MODE ? 11 : 8);
      end
      checks++;
      if (reads != (WAIT_MODE ? 5 : 2)) begin
         failures++;
         $display("FAIL ld_wait_reads: got %0d expected %0d", reads, WAIT_MODE ? 5 : 2);
      end
      realign();
      // st with mem_ready low for the first two cycles of T7
      cyc = 0; writes = 0; dones = 0; done_at = 0; seen_t0 = 1'b0;
      while (cyc < 40 && !seen_t0) begin
         bus.ir        = 32'h1080_0010;
         bus.mem_ready = 1'b1;
         #1;
         if (obs[5] && writes < 2) bus.mem_ready = 1'b0;
         @(negedge clock);
         if (cyc > 0 && obs[0]) begin
            seen_t0 = 1'b1;
         end else begin
            if (obs[5]) writes++;
            if (obs[20]) begin
               dones++;
               done_at = writes;
            end
            cyc++;
            @(posedge clock);
            #1;
         end
      end
      checks++;
      if (!seen_t0 || writes != (WAIT_MODE ? 3 : 1)) begin
         failures++;
         $display("FAIL st_wait_writes: got %0d expected %0d", writes, WAIT_MODE ? 3 : 1);
      end
      checks++;
      if (dones != 1 || done_at != (WAIT_MODE ? 3 : 1)) begin
         failures++;
         $display("FAIL st_wait_done: got count %0d at write %0d expected 1 at %0d",
                  dones, done_at, WAIT_MODE ? 3 : 1);
      end
      realign();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_reset_mid_op();
      test_directed();
      test_random();
      test_mem_wait();
      test_halt();
      test_instr_stream(32'h0880_0005, 1'b0, -1, "ldi_after_halt");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
